// File: rtl/popcount_sequencer_pkg.sv
// Shared definitions for the popcount sequencer.
//   state_t : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   acc_w   : accumulator / result width for a given word width
//   idx_w   : chunk index width for a given chunk count
//   cnt_w   : per-chunk popcount width for a given chunk width
package popcount_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result must hold the value DATA_W itself, hence the extra bit.
   function automatic int acc_w(input int data_w);
      return $clog2(data_w) + 1;
   endfunction

   function automatic int idx_w(input int nchunk);
      return $clog2(nchunk) + 1;
   endfunction

   function automatic int cnt_w(input int chunk_w);
      return $clog2(chunk_w) + 1;
   endfunction

endpackage

// File: rtl/popcount_sequencer_chunk.sv
// Combinational popcount of one W-bit chunk.
//   bits  in  W      chunk to count
//   count out CW     number of ones in bits
module popcount_sequencer_chunk #(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/popcount_sequencer.sv
// Multi-cycle popcount of a DATA_W-bit word, CHUNK_W bits per cycle through
// one narrow counter. Word in and result out over valid/ready.
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        in_data valid
//   in_ready   out  1        sequencer can accept a word (IDLE only)
//   in_data    in   DATA_W   word to count
//   out_valid  out  1        out_count valid (DONE only)
//   out_ready  in   1        consumer accepts out_count
//   out_count  out  ACC_W    number of ones in the accepted word
//   busy       out  1        high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// RUN   | counting one chunk per cycle from the low end of shreg
// DONE  | result presented, waiting for out_ready
module popcount_sequencer
   import popcount_sequencer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CHUNK_W    = 8,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int ACC_W     = acc_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_count,
   output logic              busy
);

   localparam int NCHUNK = DATA_W / CHUNK_W;
   localparam int CNT_W  = cnt_w(CHUNK_W);
   localparam int IDX_W  = idx_w(NCHUNK);

   if ((DATA_W % CHUNK_W) != 0) begin : g_bad_width
      $error("popcount_sequencer: DATA_W must be a multiple of CHUNK_W");
   end

   state_t             state;
   logic [DATA_W-1:0]  shreg;
   logic [ACC_W-1:0]   acc;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   chunk_cnt;
   logic [ACC_W-1:0]   acc_sum;
   logic               last_chunk;
   logic               zero_rest;

   popcount_sequencer_chunk #(
      .W  (CHUNK_W),
      .CW (CNT_W)
   ) u_chunk (
      .bits  (shreg[CHUNK_W-1:0]),
      .count (chunk_cnt)
   );

   assign acc_sum    = acc + ACC_W'(chunk_cnt);
   assign last_chunk = (idx == IDX_W'(NCHUNK - 1));
   // Remaining bits all zero: the rest of the word cannot add anything.
   assign zero_rest  = EARLY_EXIT && (shreg == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         acc       <= '0;
         idx       <= '0;
         out_count <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg    <= in_data;
                  acc      <= '0;
                  idx      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               // Zero check wins over the add so an empty tail costs no cycles.
               if (zero_rest) begin
                  out_count <= acc;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  acc   <= acc_sum;
                  shreg <= shreg >> CHUNK_W;
                  idx   <= idx + 1'b1;
                  if (last_chunk) begin
                     out_count <= acc_sum;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               // out_count is left alone so it keeps the last result in IDLE.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Bench for popcount_sequencer: one instance with early exit, one without,
// driven from a shared clock, reset, data and out_ready.
module tb_popcount_sequencer;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_valid_e, in_ready_e, out_valid_e, busy_e;
   logic [5:0]  out_count_e;
   logic        in_valid_n, in_ready_n, out_valid_n, busy_n;
   logic [5:0]  out_count_n;

   int checks = 0;
   int errors = 0;

   popcount_sequencer #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b1)) dut_e (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_e),
      .in_ready  (in_ready_e),
      .in_data   (in_data),
      .out_valid (out_valid_e),
      .out_ready (out_ready),
      .out_count (out_count_e),
      .busy      (busy_e)
   );

   popcount_sequencer #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b0)) dut_n (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_n),
      .in_ready  (in_ready_n),
      .in_data   (in_data),
      .out_valid (out_valid_n),
      .out_ready (out_ready),
      .out_count (out_count_n),
      .busy      (busy_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          cnt;
      int          lat_e;
      int          lat_n;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Send one word to both instances, out_ready held high, and measure
   // latency from the accept edge to the edge where out_valid rises.
   task automatic apply(input vec_t v, input string tag);
      int le, ln, ce, cn;
      logic rdy_at, rdy_after;
      le = -1; ln = -1; ce = -1; cn = -1;
      rdy_at = 1'b1; rdy_after = 1'b0;
      @(negedge clk);
      out_ready  = 1'b1;
      in_data    = v.data;
      in_valid_e = 1'b1;
      in_valid_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid_e = 1'b0;
      in_valid_n = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk);
         #1;
         if (out_valid_e && le < 0) begin le = cyc; ce = int'(out_count_e); end
         if (ln > 0 && cyc == ln + 1) rdy_after = in_ready_n;
         if (out_valid_n && ln < 0) begin ln = cyc; cn = int'(out_count_n); rdy_at = in_ready_n; end
      end
      chk({tag, "_count_e"}, ce, v.cnt);
      chk({tag, "_lat_e"}, le, v.lat_e);
      chk({tag, "_count_n"}, cn, v.cnt);
      chk({tag, "_lat_n"}, ln, v.lat_n);
      chk({tag, "_inrdy_done_n"}, rdy_at, 0);
      chk({tag, "_inrdy_back_n"}, rdy_after, 1);
   endtask

   initial begin
      int   sent, recv, cycles, got;
      logic fire_in;
      int   exp_q[$];

      vecs[0] = '{32'hFFFF_FFFF, 32, 4, 4};
      vecs[1] = '{32'h0000_0000,  0, 1, 4};
      vecs[2] = '{32'h0000_0001,  1, 2, 4};
      vecs[3] = '{32'h8000_0000,  1, 4, 4};
      vecs[4] = '{32'hA5A5_0F0F, 16, 4, 4};
      vecs[5] = '{32'h0000_00FF,  8, 2, 4};
      vecs[6] = '{32'h00FF_0000,  8, 4, 4};
      vecs[7] = '{32'h0000_FF00,  8, 3, 4};
      vecs[8] = '{32'h1234_5678, 13, 4, 4};
      vecs[9] = '{32'h0000_0300,  2, 3, 4};

      rst_n = 1'b0;
      in_data = '0;
      in_valid_e = 1'b0;
      in_valid_n = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready_e, 1);
      chk("rst_out_valid", out_valid_e, 0);
      chk("rst_busy", busy_e, 0);
      chk("rst_out_count", out_count_e, 0);
      chk("rst_busy_n", busy_n, 0);

      for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Output stall: result held, input ignored while DONE.
      @(negedge clk);
      out_ready  = 1'b0;
      in_data    = 32'hA5A5_0F0F;
      in_valid_e = 1'b1;
      @(posedge clk);
      #1;
      in_valid_e = 1'b0;
      for (int i = 0; i < 10 && !out_valid_e; i++) begin
         @(posedge clk);
         #1;
      end
      chk("stall_reach_done", out_valid_e, 1);
      for (int s = 0; s < 5; s++) begin
         chk($sformatf("stall%0d_valid", s), out_valid_e, 1);
         chk($sformatf("stall%0d_count", s), out_count_e, 16);
         chk($sformatf("stall%0d_in_ready", s), in_ready_e, 0);
         @(negedge clk);
         in_valid_e = (s == 1);
         in_data    = (s == 1) ? 32'hFFFF_FFFF : 32'hA5A5_0F0F;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      in_valid_e = 1'b0;
      out_ready  = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release_valid", out_valid_e, 0);
      chk("stall_release_in_ready", in_ready_e, 1);
      chk("stall_release_keep_count", out_count_e, 16);
      @(posedge clk);
      #1;
      chk("stall_no_stray_accept", busy_e, 0);

      // Reset in the middle of RUN after two chunks.
      @(negedge clk);
      in_data    = 32'hFFFF_FFFF;
      in_valid_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrun_busy_n", busy_n, 1);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_busy_n", busy_n, 0);
      chk("midrun_rst_valid_n", out_valid_n, 0);
      chk("midrun_rst_count_e", out_count_e, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (out_valid_n || out_valid_e) got++;
      end
      chk("midrun_no_output", got, 0);
      apply('{32'h0000_00FF, 8, 2, 4}, "after_rst");

      // Random words and random output stalls against a reference queue.
      sent = 0; recv = 0; cycles = 0;
      while (recv < 500 && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         if (!in_valid_e && sent < 500 && $urandom_range(0, 3) != 0) begin
            in_valid_e = 1'b1;
            in_data    = $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         fire_in = in_valid_e && in_ready_e;
         if (fire_in) begin
            exp_q.push_back($countones(in_data));
            sent++;
         end
         if (out_valid_e && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("rand_unexpected_output", 1, 0);
            end else begin
               chk($sformatf("rand_word%0d", recv), out_count_e, exp_q.pop_front());
            end
            recv++;
         end
         @(posedge clk);
         #1;
         if (fire_in) in_valid_e = 1'b0;
      end
      chk("rand_words_received", recv, 500);
      chk("rand_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
